// File: rtl/clk_div_gen.sv
// Multi-channel clock divider with aligned one-cycle enables and a lock indicator.
// Optional macro CLK_DIV_GEN_LOCK_GATE_EN holds all channel outputs at 0 until locked.

module clk_div_gen_ch #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] div_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             gate_i,
    output logic             clk_o,
    output logic             clk_n_o,
    output logic             ce_o
);

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             clk_n_q, clk_n_d;
    logic             ce_q, ce_d;
    logic [CNT_W-1:0] d_eff;
    logic [CNT_W-1:0] half;

    // Ratios 0 and 1 cannot produce a clock, so they run as divide-by-2.
    assign d_eff = (div_q < CNT_W'(2)) ? CNT_W'(2) : div_q;
    assign half  = d_eff >> 1;

    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        clk_d   = 1'b0;
        clk_n_d = 1'b0;
        ce_d    = 1'b0;

        if (en_i && gate_i) begin
            clk_d   = (cnt_q < half);
            clk_n_d = !(cnt_q < half);
            ce_d    = (cnt_q == '0);
        end

        if (load_i) begin
            div_d = div_i;
            cnt_d = '0;
        end else if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q >= d_eff - CNT_W'(1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= CNT_W'(DEFAULT_DIV);
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            clk_n_q <= 1'b0;
            ce_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            clk_n_q <= clk_n_d;
            ce_q    <= ce_d;
        end
    end

    assign clk_o   = clk_q;
    assign clk_n_o = clk_n_q;
    assign ce_o    = ce_q;

endmodule

module clk_div_gen #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*CNT_W-1:0] div_ratio,
    input  logic                    load,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       clk_out_n,
    output logic [NUM_CH-1:0]       ce_out,
    output logic                    locked
);

    localparam int LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_CYCLES - 1);

    typedef enum logic {
        LOCKING,
        LOCKED
    } lk_state_t;

    lk_state_t                        state_q, state_d;
    logic [LK_W-1:0]                  lk_cnt_q, lk_cnt_d;
    logic                             locked_q, locked_d;
    logic                             out_en;
    logic [NUM_CH-1:0][CNT_W-1:0]     ratio;

    assign ratio = div_ratio;

`ifdef CLK_DIV_GEN_LOCK_GATE_EN
    assign out_en = locked_q;
`else
    assign out_en = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        lk_cnt_d = lk_cnt_q;
        locked_d = locked_q;
        case (state_q)
            LOCKING: begin
                locked_d = 1'b0;
                if (load) begin
                    lk_cnt_d = '0;
                end else if (lk_cnt_q == LK_LAST) begin
                    state_d  = LOCKED;
                    lk_cnt_d = '0;
                    locked_d = 1'b1;
                end else begin
                    lk_cnt_d = lk_cnt_q + LK_W'(1);
                end
            end
            LOCKED: begin
                locked_d = 1'b1;
                if (load) begin
                    state_d  = LOCKING;
                    lk_cnt_d = '0;
                    locked_d = 1'b0;
                end
            end
            default: begin
                state_d  = LOCKING;
                lk_cnt_d = '0;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOCKING;
            lk_cnt_q <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lk_cnt_q <= lk_cnt_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_gen_ch #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .div_i  (ratio[g]),
            .load_i (load),
            .en_i   (ch_en[g]),
            .gate_i (out_en),
            .clk_o  (clk_out[g]),
            .clk_n_o(clk_out_n[g]),
            .ce_o   (ce_out[g])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: directed and random load/enable traffic against a
// model that derives each output from elapsed edges since the channel's last restart.

module tb_clk_div_gen;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 2;
    localparam int LOCK_CYCLES = 16;

    logic                    clk;
    logic                    rst;
    logic [NUM_CH*CNT_W-1:0] div_ratio;
    logic                    load;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       clk_out_n;
    logic [NUM_CH-1:0]       ce_out;
    logic                    locked;

    clk_div_gen #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .div_ratio(div_ratio),
        .load     (load),
        .ch_en    (ch_en),
        .clk_out  (clk_out),
        .clk_out_n(clk_out_n),
        .ce_out   (ce_out),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: edge index since reset release, last restart edge of the
    // lock timer, first aligned edge per channel, and the active ratio.
    int t;
    int lk_start;
    int t0   [NUM_CH];
    int mdiv [NUM_CH];
    logic exp_locked_prev;

    logic [NUM_CH-1:0] exp_clk, exp_clk_n, exp_ce;
    logic              exp_locked;

    task automatic model_reset();
        t = 0;
        lk_start = 0;
        exp_locked_prev = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            t0[i]   = 1;
            mdiv[i] = DEFAULT_DIV;
        end
        exp_clk = '0; exp_clk_n = '0; exp_ce = '0; exp_locked = 1'b0;
    endtask

    task automatic check_all(input string tag);
        n_assert++;
        assert (clk_out === exp_clk) else begin
            n_fail++;
            $error("FAIL %s clk_out t=%0d: observed %b expected %b", tag, t, clk_out, exp_clk);
        end
        n_assert++;
        assert (clk_out_n === exp_clk_n) else begin
            n_fail++;
            $error("FAIL %s clk_out_n t=%0d: observed %b expected %b", tag, t, clk_out_n, exp_clk_n);
        end
        n_assert++;
        assert (ce_out === exp_ce) else begin
            n_fail++;
            $error("FAIL %s ce_out t=%0d: observed %b expected %b", tag, t, ce_out, exp_ce);
        end
        n_assert++;
        assert (locked === exp_locked) else begin
            n_fail++;
            $error("FAIL %s locked t=%0d: observed %b expected %b", tag, t, locked, exp_locked);
        end
    endtask

    // One rising edge with the currently driven inputs, then compare.
    task automatic step(input string tag);
        int d, pos;
        @(posedge clk);
        t++;
        for (int i = 0; i < NUM_CH; i++) begin
            d = (mdiv[i] < 2) ? 2 : mdiv[i];
            if (ch_en[i]) begin
                pos          = (t - t0[i]) % d;
                exp_clk[i]   = (pos < d / 2);
                exp_clk_n[i] = !(pos < d / 2);
                exp_ce[i]    = (pos == 0);
            end else begin
                exp_clk[i] = 1'b0; exp_clk_n[i] = 1'b0; exp_ce[i] = 1'b0;
                t0[i] = t + 1;
            end
`ifdef CLK_DIV_GEN_LOCK_GATE_EN
            if (!exp_locked_prev) begin
                exp_clk[i] = 1'b0; exp_clk_n[i] = 1'b0; exp_ce[i] = 1'b0;
            end
`endif
        end
        if (load) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mdiv[i] = int'(div_ratio[i*CNT_W +: CNT_W]);
                t0[i]   = t + 1;
            end
            lk_start = t;
        end
        exp_locked = ((t - lk_start) >= LOCK_CYCLES);
        exp_locked_prev = exp_locked;
        #1;
        check_all(tag);
    endtask

    task automatic set_ratios(input int r0, input int r1, input int r2, input int r3);
        div_ratio[0*CNT_W +: CNT_W] = CNT_W'(r0);
        div_ratio[1*CNT_W +: CNT_W] = CNT_W'(r1);
        div_ratio[2*CNT_W +: CNT_W] = CNT_W'(r2);
        div_ratio[3*CNT_W +: CNT_W] = CNT_W'(r3);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; ch_en = '1; div_ratio = '0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Defaults: divide by 2 from the first edge, lock after 16 edges.
        for (int k = 0; k < 20; k++) step("default");

        // Mixed ratios 2/3/4/7, aligned restart.
        set_ratios(2, 3, 4, 7);
        load = 1'b1;
        step("load_mix");
        load = 1'b0;
        for (int k = 0; k < 30; k++) step("mix");

        // Ratios 0 and 1 behave as 2.
        set_ratios(0, 1, 5, 6);
        load = 1'b1;
        step("load_01");
        load = 1'b0;
        for (int k = 0; k < 20; k++) step("ratio01");

        // Channel 2 disabled for 5 cycles, re-enabled, then realigned by load.
        set_ratios(3, 4, 5, 6);
        load = 1'b1;
        step("load_en");
        load = 1'b0;
        for (int k = 0; k < 4; k++) step("pre_dis");
        ch_en[2] = 1'b0;
        for (int k = 0; k < 5; k++) step("ch2_off");
        ch_en[2] = 1'b1;
        for (int k = 0; k < 8; k++) step("ch2_on");
        load = 1'b1;
        step("realign");
        load = 1'b0;
        for (int k = 0; k < 12; k++) step("realigned");

        // Load held high for several cycles.
        load = 1'b1;
        for (int k = 0; k < 3; k++) step("load_held");
        load = 1'b0;
        for (int k = 0; k < 20; k++) step("after_held");

        // Random ratios, loads and enables.
        for (int k = 0; k < 150; k++) begin
            load = ($urandom_range(0, 11) == 0);
            if (load) begin
                for (int i = 0; i < NUM_CH; i++)
                    div_ratio[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 12));
            end
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(0, 9) == 0) ch_en[i] = ~ch_en[i];
            step("random");
        end
        load = 1'b0; ch_en = '1;
        for (int k = 0; k < 5; k++) step("settle");

        // Asynchronous reset mid-period with ratio 7 loaded.
        set_ratios(7, 7, 7, 7);
        load = 1'b1;
        step("load7");
        load = 1'b0;
        for (int k = 0; k < 20; k++) step("run7");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk); #1;
        check_all("rst_held");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) step("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
